// File: rtl/freq_ctrl_pkg.sv
// Shared types, widths and the saturating edge accumulator used by the
// frequency-counter measurement sequencer.
package freq_ctrl_pkg;

    localparam int PERIOD_W = 12;
    localparam int EDGE_W   = 7;

    localparam logic [PERIOD_W-1:0] DEFAULT_PERIOD = 12'd1000;
    localparam logic [EDGE_W-1:0]   MAX_EDGES      = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    typedef struct packed {
        logic [EDGE_W-1:0] count;
        logic              ovf;
    } edge_acc_t;

    // Count one edge unless already at the two-digit display limit, in which
    // case the count freezes and the overflow flag latches.
    function automatic edge_acc_t edge_accumulate(input edge_acc_t acc, input logic pulse);
        edge_acc_t res;
        res = acc;
        if (pulse) begin
            if (acc.count < MAX_EDGES) begin
                res.count = acc.count + 7'd1;
            end else begin
                res.ovf = 1'b1;
            end
        end else begin
            res = acc;
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for the raw measured signal followed by a delay flop
// so a rising edge yields exactly one single-cycle pulse.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic rise_pulse
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Synchroniser chain plus edge-detect delay stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= d_async;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rise_pulse = sync_q & ~dly_q;

endmodule

// File: rtl/meas_gate_ctrl.sv
// Measurement sequencer: opens a programmable gate, counts synchronised
// rising edges inside it and hands the count downstream over valid/ready.
module meas_gate_ctrl
    import freq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                signal,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_load,
    input  logic                result_ready,
    output logic                result_valid,
    output logic [EDGE_W-1:0]   result_count,
    output logic                result_ovf,
    output logic                gate_active,
    output logic [1:0]          dbg_state
);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_reg_q, period_reg_d;
    logic [PERIOD_W-1:0] active_period_q, active_period_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    edge_acc_t           acc_q, acc_d;
    logic                res_valid_q, res_valid_d;
    logic [EDGE_W-1:0]   res_count_q, res_count_d;
    logic                res_ovf_q, res_ovf_d;

    logic                edge_pulse_s;
    edge_acc_t           acc_next_s;
    logic                last_cycle_s;

    edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_async    (signal),
        .rise_pulse (edge_pulse_s)
    );

    assign acc_next_s   = edge_accumulate(acc_q, edge_pulse_s);
    // Only meaningful in GATE, where active_period_q is always at least one.
    assign last_cycle_s = (timer_q == (active_period_q - 12'd1));

    // Period register: a zero period is rejected so the gate never degenerates.
    always_comb begin
        period_reg_d = period_reg_q;
        if (period_load && (period != {PERIOD_W{1'b0}})) begin
            period_reg_d = period;
        end else begin
            period_reg_d = period_reg_q;
        end
    end

    // Sequencer next-state, gate timer, edge counter and result capture.
    always_comb begin
        state_d         = state_q;
        active_period_d = active_period_q;
        timer_d         = timer_q;
        acc_d           = acc_q;
        res_valid_d     = res_valid_q;
        res_count_d     = res_count_q;
        res_ovf_d       = res_ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ARM: begin
                active_period_d = period_reg_q;
                timer_d         = {PERIOD_W{1'b0}};
                acc_d           = '0;
                if (enable) begin
                    state_d = ST_GATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GATE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 12'd1;
                    acc_d   = acc_next_s;
                    // The pulse of the closing cycle is folded into the result.
                    if (last_cycle_s) begin
                        res_count_d = acc_next_s.count;
                        res_ovf_d   = acc_next_s.ovf;
                        res_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        state_d = ST_GATE;
                    end
                end
            end

            ST_HOLD: begin
                if (res_valid_q && result_ready) begin
                    res_valid_d = 1'b0;
                    if (enable) begin
                        state_d = ST_ARM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State, counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            period_reg_q    <= DEFAULT_PERIOD;
            active_period_q <= {PERIOD_W{1'b0}};
            timer_q         <= {PERIOD_W{1'b0}};
            acc_q           <= '0;
            res_valid_q     <= 1'b0;
            res_count_q     <= {EDGE_W{1'b0}};
            res_ovf_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            period_reg_q    <= period_reg_d;
            active_period_q <= active_period_d;
            timer_q         <= timer_d;
            acc_q           <= acc_d;
            res_valid_q     <= res_valid_d;
            res_count_q     <= res_count_d;
            res_ovf_q       <= res_ovf_d;
        end
    end

    assign result_valid = res_valid_q;
    assign result_count = res_count_q;
    assign result_ovf   = res_ovf_q;
    assign gate_active  = (state_q == ST_GATE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_meas_gate_ctrl.sv
// Scoreboard bench for meas_gate_ctrl: directed scenarios push hand-computed
// results, a monitor pops and compares them at every handshake.
module tb_meas_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        signal = 1'b0;
    logic        enable;
    logic [11:0] period;
    logic        period_load;
    logic        result_ready;
    logic        result_valid;
    logic [6:0]  result_count;
    logic        result_ovf;
    logic        gate_active;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];     // {ovf, count}
    int         gate_lens[$];
    int         glen = 0;

    int   sig_mode  = 0;      // 0 low, 1 square/10, 2 toggle, 3 manual level
    logic man_level = 1'b0;
    int   ph        = 0;

    meas_gate_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signal       (signal),
        .enable       (enable),
        .period       (period),
        .period_load  (period_load),
        .result_ready (result_ready),
        .result_valid (result_valid),
        .result_count (result_count),
        .result_ovf   (result_ovf),
        .gate_active  (gate_active),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int glen_at(input int i);
        if (gate_lens.size() > i) return gate_lens[i];
        else return -1;
    endfunction

    // Signal generator, updated on the falling edge away from DUT sampling.
    initial forever begin
        @(negedge clk);
        case (sig_mode)
            0: signal = 1'b0;
            1: begin
                signal = (ph < 5);
                ph = (ph + 1) % 10;
            end
            2: signal = ~signal;
            default: signal = man_level;
        endcase
    end

    // Scoreboard monitor and gate-length tracker.
    initial forever begin
        logic [7:0] e;
        @(negedge clk);
        if (rst_n === 1'b1 && result_valid === 1'b1 && result_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got count=%0d ovf=%0d, required no result",
                         result_count, result_ovf);
            end else begin
                e = exp_q.pop_front();
                check("result_count", {25'd0, result_count}, {25'd0, e[6:0]});
                check("result_ovf", {31'd0, result_ovf}, {31'd0, e[7]});
            end
        end
        if (gate_active === 1'b1) begin
            glen++;
        end else if (glen != 0) begin
            gate_lens.push_back(glen);
            glen = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_period(input logic [11:0] v);
        tick();
        period      = v;
        period_load = 1'b1;
        tick();
        period_load = 1'b0;
    endtask

    task automatic wait_hs(output int c);
        bit ok;
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1 && result_ready === 1'b1) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
        check("handshake_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_gate();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gate_active === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("gate_opened", {31'd0, ok}, 32'd1);
    endtask

    task automatic run_results(input int n);
        int c;
        tick();
        enable       = 1'b1;
        result_ready = 1'b1;
        for (int i = 0; i < n; i++) wait_hs(c);
        tick();
        enable = 1'b0;
    endtask

    initial begin
        int  c1, c2, vcnt;
        bit  ok;

        rst_n = 1'b0; enable = 1'b0; period_load = 1'b0; period = 12'd0;
        result_ready = 1'b0; sig_mode = 2;
        repeat (4) @(negedge clk);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_count", {25'd0, result_count}, 32'd0);
        check("rst_ovf", {31'd0, result_ovf}, 32'd0);
        check("rst_gate", {31'd0, gate_active}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_state", {30'd0, dbg_state}, 32'd0);
            check("idle_valid", {31'd0, result_valid}, 32'd0);
        end

        // Nominal: period 100, one rise every 10 cycles.
        tick();
        sig_mode = 1;
        repeat (12) tick();
        load_period(12'd100);
        exp_q.push_back({1'b0, 7'd10});
        exp_q.push_back({1'b0, 7'd10});
        tick();
        enable = 1'b1; result_ready = 1'b1;
        wait_hs(c1);
        wait_hs(c2);
        tick();
        enable = 1'b0;
        check("result_interval", c2 - c1, 32'd102);

        // Saturation: 500 rises in a 1000-cycle gate.
        sig_mode = 2;
        repeat (12) tick();
        load_period(12'd1000);
        exp_q.push_back({1'b1, 7'd99});
        run_results(1);

        // Backpressure.
        sig_mode = 1;
        repeat (12) tick();
        load_period(12'd100);
        exp_q.push_back({1'b0, 7'd10});
        tick();
        enable = 1'b1; result_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("hold_state", {30'd0, dbg_state}, 32'd3);
            check("hold_valid", {31'd0, result_valid}, 32'd1);
            check("hold_count", {25'd0, result_count}, 32'd10);
            check("hold_ovf", {31'd0, result_ovf}, 32'd0);
        end
        tick();
        result_ready = 1'b1;
        wait_hs(c1);
        tick();
        enable = 1'b0;
        @(negedge clk);
        check("arm_after_hs", {30'd0, dbg_state}, 32'd1);
        check("valid_cleared", {31'd0, result_valid}, 32'd0);

        // Zero period load is ignored.
        sig_mode = 0;
        repeat (4) tick();
        load_period(12'd37);
        load_period(12'd0);
        gate_lens.delete();
        exp_q.push_back({1'b0, 7'd0});
        run_results(1);
        check("p0_ignored_len", glen_at(0), 32'd37);

        // Period 1 with a pulse landing in the single gate cycle.
        sig_mode = 3; man_level = 1'b0;
        repeat (4) tick();
        load_period(12'd1);
        gate_lens.delete();
        exp_q.push_back({1'b0, 7'd1});
        tick();
        enable = 1'b1; result_ready = 1'b1; man_level = 1'b1;
        wait_hs(c1);
        tick();
        enable = 1'b0; man_level = 1'b0;
        check("p1_len", glen_at(0), 32'd1);

        // Period reload mid-gate applies only to the next gate.
        sig_mode = 0;
        load_period(12'd80);
        gate_lens.delete();
        exp_q.push_back({1'b0, 7'd0});
        exp_q.push_back({1'b0, 7'd0});
        tick();
        enable = 1'b1; result_ready = 1'b1;
        wait_gate();
        repeat (20) tick();
        load_period(12'd50);
        wait_hs(c1);
        wait_hs(c2);
        tick();
        enable = 1'b0;
        check("reload_len_cur", glen_at(0), 32'd80);
        check("reload_len_next", glen_at(1), 32'd50);

        // Abort by dropping enable mid-gate.
        sig_mode = 1;
        tick();
        enable = 1'b1;
        wait_gate();
        repeat (20) tick();
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        check("abort_gate", {31'd0, gate_active}, 32'd0);
        vcnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (result_valid !== 1'b0) vcnt++;
        end
        check("abort_no_result", vcnt, 32'd0);

        // Reset mid-gate, then the default period must be back.
        tick();
        enable = 1'b1;
        wait_gate();
        repeat (10) tick();
        rst_n = 1'b0; enable = 1'b0;
        #1;
        check("midrst_state", {30'd0, dbg_state}, 32'd0);
        check("midrst_gate", {31'd0, gate_active}, 32'd0);
        check("midrst_valid", {31'd0, result_valid}, 32'd0);
        check("midrst_count", {25'd0, result_count}, 32'd0);
        check("midrst_ovf", {31'd0, result_ovf}, 32'd0);
        tick();
        rst_n = 1'b1;
        sig_mode = 0;
        repeat (4) tick();
        gate_lens.delete();
        exp_q.push_back({1'b0, 7'd0});
        run_results(1);
        check("default_period_len", glen_at(0), 32'd1000);

        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
